// File: rtl/sd_block_arbiter.sv
// Shares one SD-card block reader between the audio and video fetch paths, one sector per grant.
// Optional grant/error statistics outputs are enabled by defining SD_ARB_STATS_EN.
module sd_block_arbiter #(
    parameter int unsigned SECTOR_W       = 32,
    parameter int unsigned BLOCK_BYTES    = 512,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                MasterCLK,
    input  logic                Reset,
    input  logic                AudReq,
    input  logic                AudUrgent,
    input  logic [SECTOR_W-1:0] AudSector,
    output logic                AudGrant,
    output logic                AudValid,
    output logic                AudDone,
    output logic                AudErr,
    input  logic                VidReq,
    input  logic [SECTOR_W-1:0] VidSector,
    output logic                VidGrant,
    output logic                VidValid,
    output logic                VidDone,
    output logic                VidErr,
    output logic [7:0]          RdData,
    output logic                SdStart,
    output logic [SECTOR_W-1:0] SdSector,
    input  logic                SdBusy,
    input  logic                SdDataValid,
    input  logic [7:0]          SdData,
    input  logic                SdDone,
    input  logic                SdError
`ifdef SD_ARB_STATS_EN
    ,
    output logic [15:0]         AudGrantCount,
    output logic [15:0]         VidGrantCount,
    output logic [7:0]          ErrCount
`endif
);

    localparam int unsigned CntW = $clog2(BLOCK_BYTES) + 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StStream, StFinish} state_e;

    state_e              state_q, state_d;
    logic                owner_q;        // 0: audio, 1: video
    logic                rr_q;           // side preferred when both request
    logic [SECTOR_W-1:0] sd_sector_q;
    logic [CntW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [TmoW-1:0]     tmo_cnt_q;
    logic                ovf_q, ovf_d;
    logic                fin_err_q, fin_err_d;
    logic [7:0]          rd_data_q;
    logic                aud_valid_q, vid_valid_q;

    logic win_vid, byte_take, in_block, tmo_hit, owner_req, busy_phase;

    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        win_vid    = (AudReq && AudUrgent) ? 1'b0 : ((AudReq && VidReq) ? rr_q : VidReq);
        busy_phase = (state_q == StWaitBusy) || (state_q == StStream);
        tmo_hit    = busy_phase && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
        in_block   = byte_cnt_q < CntW'(BLOCK_BYTES);
        byte_take  = (state_q == StStream) && SdDataValid;
        owner_req  = owner_q ? VidReq : AudReq;
        byte_cnt_d = byte_cnt_q + CntW'(byte_take && in_block);
        ovf_d      = ovf_q || (byte_take && !in_block);
        fin_err_d  = SdError || tmo_hit || ovf_d || (byte_cnt_d != CntW'(BLOCK_BYTES));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (AudReq || VidReq) state_d = StIssue;
            StIssue:    state_d = StWaitBusy;
            StWaitBusy: begin
                if (SdError || tmo_hit || SdDone) state_d = StFinish;
                else if (SdBusy)                  state_d = StStream;
            end
            StStream:   if (SdError || tmo_hit || SdDone) state_d = StFinish;
            StFinish:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            sd_sector_q <= '0;
            byte_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            fin_err_q   <= 1'b0;
            rd_data_q   <= '0;
            aud_valid_q <= 1'b0;
            vid_valid_q <= 1'b0;
        end else begin
            aud_valid_q <= 1'b0;
            vid_valid_q <= 1'b0;
            if (state_q == StIdle && state_d == StIssue) begin
                owner_q     <= win_vid;
                rr_q        <= ~win_vid;
                sd_sector_q <= win_vid ? VidSector : AudSector;
            end
            if (state_q == StIssue || busy_phase) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_q <= '0;
            end
            if (busy_phase) begin
                byte_cnt_q <= byte_cnt_d;
                ovf_q      <= ovf_d;
            end else begin
                byte_cnt_q <= '0;
                ovf_q      <= 1'b0;
            end
            if (busy_phase && state_d == StFinish) begin
                fin_err_q <= fin_err_d;
            end
            // Bytes are still consumed once the owner has dropped its request, just not strobed.
            if (byte_take && in_block) begin
                rd_data_q   <= SdData;
                aud_valid_q <= !owner_q && owner_req;
                vid_valid_q <= owner_q && owner_req;
            end
        end
    end

    always_comb begin
        AudGrant = 1'b0;
        VidGrant = 1'b0;
        AudDone  = 1'b0;
        AudErr   = 1'b0;
        VidDone  = 1'b0;
        VidErr   = 1'b0;
        SdStart  = (state_q == StIssue);
        if (state_q == StIssue || busy_phase) begin
            AudGrant = !owner_q;
            VidGrant = owner_q;
        end
        if (state_q == StFinish) begin
            AudDone = !owner_q && !fin_err_q;
            AudErr  = !owner_q && fin_err_q;
            VidDone = owner_q && !fin_err_q;
            VidErr  = owner_q && fin_err_q;
        end
        AudValid = aud_valid_q;
        VidValid = vid_valid_q;
        RdData   = rd_data_q;
        SdSector = sd_sector_q;
    end

`ifdef SD_ARB_STATS_EN
    logic [15:0] aud_gnt_cnt_q, vid_gnt_cnt_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            aud_gnt_cnt_q <= '0;
            vid_gnt_cnt_q <= '0;
            err_cnt_q     <= '0;
        end else begin
            if (state_q == StIdle && state_d == StIssue) begin
                if (!win_vid && aud_gnt_cnt_q != 16'hFFFF) aud_gnt_cnt_q <= aud_gnt_cnt_q + 1'b1;
                if (win_vid && vid_gnt_cnt_q != 16'hFFFF)  vid_gnt_cnt_q <= vid_gnt_cnt_q + 1'b1;
            end
            if (state_q == StFinish && fin_err_q && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign AudGrantCount = aud_gnt_cnt_q;
    assign VidGrantCount = vid_gnt_cnt_q;
    assign ErrCount      = err_cnt_q;
`endif

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed plus randomized bench for sd_block_arbiter; the bench plays the SD reader and
// both requesters and checks against a transaction-level model of arbitration and blocks.
module tb_sd_block_arbiter;
    localparam int unsigned SW = 32;
    localparam int unsigned BB = 32;
    localparam int unsigned TO = 100;

    logic          MasterCLK = 0;
    logic          Reset = 0;
    logic          AudReq = 0, AudUrgent = 0, VidReq = 0;
    logic [SW-1:0] AudSector = '0, VidSector = '0;
    logic          AudGrant, AudValid, AudDone, AudErr;
    logic          VidGrant, VidValid, VidDone, VidErr;
    logic [7:0]    RdData;
    logic          SdStart;
    logic [SW-1:0] SdSector;
    logic          SdBusy = 0, SdDataValid = 0, SdDone = 0, SdError = 0;
    logic [7:0]    SdData = '0;
`ifdef SD_ARB_STATS_EN
    logic [15:0]   AudGrantCount, VidGrantCount;
    logic [7:0]    ErrCount;
`endif

    sd_block_arbiter #(
        .SECTOR_W      (SW),
        .BLOCK_BYTES   (BB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .MasterCLK  (MasterCLK),
        .Reset      (Reset),
        .AudReq     (AudReq),
        .AudUrgent  (AudUrgent),
        .AudSector  (AudSector),
        .AudGrant   (AudGrant),
        .AudValid   (AudValid),
        .AudDone    (AudDone),
        .AudErr     (AudErr),
        .VidReq     (VidReq),
        .VidSector  (VidSector),
        .VidGrant   (VidGrant),
        .VidValid   (VidValid),
        .VidDone    (VidDone),
        .VidErr     (VidErr),
        .RdData     (RdData),
        .SdStart    (SdStart),
        .SdSector   (SdSector),
        .SdBusy     (SdBusy),
        .SdDataValid(SdDataValid),
        .SdData     (SdData),
        .SdDone     (SdDone),
        .SdError    (SdError)
`ifdef SD_ARB_STATS_EN
        ,
        .AudGrantCount(AudGrantCount),
        .VidGrantCount(VidGrantCount),
        .ErrCount     (ErrCount)
`endif
    );

    always #5 MasterCLK = ~MasterCLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit mon_en = 0;
    int ptr_m = 0;                 // model: side preferred on a tie (0 audio, 1 video)
    int st_aud = 0, st_vid = 0, st_err = 0;
    logic [8:0] exp_q[$];          // {side, byte}
    logic [8:0] got_q[$];

    always @(posedge MasterCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {15'd0, AudGrant, AudValid, AudDone, AudErr, VidGrant, VidValid, VidDone, VidErr,
                SdStart, RdData, SdSector};
    endfunction

    // Collect strobed bytes and check the single-owner invariants every cycle.
    always @(negedge MasterCLK) begin
        if (mon_en) begin
            if (AudValid) got_q.push_back({1'b0, RdData});
            if (VidValid) got_q.push_back({1'b1, RdData});
            chk("one_grant", {63'd0, AudGrant && VidGrant}, 64'd0);
            chk("valid_owner", {62'd0, AudValid && !AudGrant, VidValid && !VidGrant}, 64'd0);
        end
    end

    task automatic chk_stats();
`ifdef SD_ARB_STATS_EN
        chk("aud_grant_count", AudGrantCount, st_aud);
        chk("vid_grant_count", VidGrantCount, st_vid);
        chk("err_count", ErrCount, st_err);
`endif
    endtask

    // kind: 0 SdDone, 1 SdError, 2 no SdDone (timeout), 3 reset mid-stream,
    //       4 owner drops Req mid-stream, 5 audio raises urgent request mid-stream
    task automatic xfer(input bit a, input bit v, input bit u, input int nbytes, input int kind);
        int w;
        bit dropped, exp_err, seen;
        int t0;
        logic [SW-1:0] sa, sv;
        logic [7:0] d;
        sa = $urandom;
        sv = $urandom;
        AudReq = a; VidReq = v; AudUrgent = u; AudSector = sa; VidSector = sv;
        if (u && a)       w = 0;
        else if (a && !v) w = 0;
        else if (v && !a) w = 1;
        else              w = ptr_m;
        ptr_m = 1 - w;
        if (w == 0) st_aud++; else st_vid++;
        exp_err = (kind == 1) || (kind == 2) || (nbytes != BB);
        exp_q.delete();
        got_q.delete();
        @(negedge MasterCLK);
        chk("sd_start", SdStart, 1);
        chk("sd_sector", SdSector, (w != 0) ? sv : sa);
        chk("grant", {AudGrant, VidGrant}, (w != 0) ? 2'b01 : 2'b10);
        t0 = cyc;
        SdBusy = 1;
        @(negedge MasterCLK);
        chk("start_one_cycle", SdStart, 0);
        @(negedge MasterCLK);
        dropped = 0;
        for (int i = 0; i < nbytes; i++) begin
            if ($urandom_range(3) == 0) begin
                SdDataValid = 0;
                @(negedge MasterCLK);
            end
            if (i == nbytes / 2) begin
                if (kind == 3) begin
                    Reset = 0; SdDataValid = 0; SdBusy = 0;
                    @(negedge MasterCLK);
                    chk("reset_outputs", all_out(), 0);
                    st_aud = 0; st_vid = 0; st_err = 0;
                    chk_stats();
                    Reset = 1; AudReq = 0; VidReq = 0; AudUrgent = 0;
                    ptr_m = 0;
                    @(negedge MasterCLK);
                    chk("reset_idle", {AudGrant, VidGrant, SdStart}, 0);
                    got_q.delete();
                    return;
                end
                if (kind == 4) begin
                    if (w != 0) VidReq = 0; else AudReq = 0;
                    dropped = 1;
                end
                if (kind == 5) begin
                    AudReq = 1; AudUrgent = 1; AudSector = $urandom;
                end
                chk("grant_mid", {AudGrant, VidGrant}, (w != 0) ? 2'b01 : 2'b10);
            end
            d = $urandom;
            SdDataValid = 1;
            SdData = d;
            if (i < BB && !dropped) exp_q.push_back({w[0], d});
            @(negedge MasterCLK);
        end
        SdDataValid = 0;
        if (kind == 1) begin
            SdError = 1;
            SdDone = $urandom_range(1);
        end else if (kind != 2) begin
            SdDone = 1;
        end
        seen = 0;
        for (int k = 0; k < int'(TO) + 20 && !seen; k++) begin
            @(negedge MasterCLK);
            SdDone = 0;
            SdError = 0;
            seen = AudDone | AudErr | VidDone | VidErr;
        end
        chk("result_seen", seen, 1);
        chk("result", {AudDone, AudErr, VidDone, VidErr},
            (w != 0) ? {2'b00, !exp_err, exp_err} : {!exp_err, exp_err, 2'b00});
        chk("grant_drop", {AudGrant, VidGrant}, 0);
        if (kind == 2) chk("timeout_cycle", cyc - t0, TO);
        if (exp_err) st_err++;
        chk("byte_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("byte", got_q[i], exp_q[i]);
        AudReq = 0; VidReq = 0; AudUrgent = 0; SdBusy = 0;
        @(negedge MasterCLK);
        chk("back_idle", {AudGrant, VidGrant, SdStart, AudDone, AudErr, VidDone, VidErr}, 0);
        chk_stats();
    endtask

    initial begin
        bit ra, rv;
        int nb, kd;
        repeat (3) @(negedge MasterCLK);
        chk("reset_state", all_out(), 0);
        chk_stats();
        Reset = 1;
        mon_en = 1;
        @(negedge MasterCLK);

        // Tie from reset: Aud, Vid, Aud with one idle cycle between blocks.
        xfer(1, 1, 0, BB, 0);
        xfer(1, 1, 0, BB, 0);
        xfer(1, 1, 0, BB, 0);
        // Single audio read at sector 0x1000.
        AudSector = 32'h0000_1000;
        AudReq = 1;
        @(negedge MasterCLK);
        chk("single_sector", SdSector, 32'h0000_1000);
        chk("single_start", SdStart, 1);
        AudReq = 0;
        SdBusy = 0;
        ptr_m = 1;
        st_aud++;
        // Let it finish via an early SdDone (no bytes) and confirm the error path.
        @(negedge MasterCLK);
        @(negedge MasterCLK);
        SdDone = 1;
        @(negedge MasterCLK);
        SdDone = 0;
        chk("early_done_err", {AudDone, AudErr}, 2'b01);
        st_err++;
        @(negedge MasterCLK);
        xfer(1, 0, 0, BB, 0);
        // Urgent audio beats pointer=video.
        xfer(1, 1, 1, BB, 0);
        // Video holds grant while audio turns urgent; audio wins next.
        xfer(0, 1, 0, BB, 5);
        xfer(1, 1, 1, BB, 0);
        // Short and long blocks.
        xfer(0, 1, 0, BB - 1, 0);
        xfer(0, 1, 0, BB + 1, 0);
        // Timeout, reader error, requester drop.
        xfer(1, 0, 0, 10, 2);
        xfer(0, 1, 0, BB, 1);
        xfer(1, 0, 0, BB, 4);
        // Reset mid-stream, then re-arbitration from pointer=audio.
        xfer(0, 1, 0, BB, 0);
        xfer(1, 1, 0, BB, 3);
        xfer(1, 1, 0, BB, 0);

        for (int n = 0; n < 10; n++) begin
            ra = $urandom_range(1);
            rv = $urandom_range(1);
            if (!ra && !rv) rv = 1;
            case ($urandom_range(3))
                0: nb = BB - 1;
                1: nb = BB + 1;
                default: nb = BB;
            endcase
            case ($urandom_range(3))
                0: kd = 1;
                1: kd = 4;
                default: kd = 0;
            endcase
            xfer(ra, rv, ra && ($urandom_range(1) == 1), nb, kd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
